// File: rtl/vadd_arbiter.sv
// Two-requester round-robin front end for a shared LANES x WIDTH vector adder.
// Registers operands on grant and tags each op so its result returns to the issuer.
module vadd_arbiter #(
    parameter int LAT   = 1,
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [LANES*WIDTH-1:0] req0_a,
    input  logic [LANES*WIDTH-1:0] req0_b,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [LANES*WIDTH-1:0] req1_a,
    input  logic [LANES*WIDTH-1:0] req1_b,
    output logic                   rsp0_valid,
    output logic [LANES*WIDTH-1:0] rsp0_y,
    output logic                   rsp1_valid,
    output logic [LANES*WIDTH-1:0] rsp1_y,
    output logic                   dp_en,
    output logic [LANES*WIDTH-1:0] dp_a,
    output logic [LANES*WIDTH-1:0] dp_b,
    input  logic [LANES*WIDTH-1:0] dp_y,
    output logic                   busy,
    output logic [CNTW-1:0]        done0_cnt,
    output logic [CNTW-1:0]        done1_cnt
);

    logic         last_grant;  // 1 when requester 1 was granted most recently
    logic         grant0;
    logic         grant1;
    logic         grant_any;
    logic [LAT:0] tag_v;       // entry 0 is the issue register; entry LAT meets dp_y
    logic [LAT:0] tag_id;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign grant_any  = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
            tag_v      <= '0;
            tag_id     <= '0;
            dp_a       <= '0;
            dp_b       <= '0;
            done0_cnt  <= '0;
            done1_cnt  <= '0;
        end else begin
            tag_v  <= {tag_v[LAT-1:0], grant_any};
            tag_id <= {tag_id[LAT-1:0], grant1};
            if (grant_any) begin
                last_grant <= grant1;
                dp_a       <= grant1 ? req1_a : req0_a;
                dp_b       <= grant1 ? req1_b : req0_b;
            end
            if (rsp0_valid) begin
                done0_cnt <= done0_cnt + CNTW'(1);
            end
            if (rsp1_valid) begin
                done1_cnt <= done1_cnt + CNTW'(1);
            end
        end
    end

    // Datapath only advances while something is live, so results stay aligned to tags.
    assign dp_en      = |tag_v;
    assign busy       = |tag_v;
    assign rsp0_valid = !reset && tag_v[LAT] && !tag_id[LAT];
    assign rsp1_valid = !reset && tag_v[LAT] &&  tag_id[LAT];
    assign rsp0_y     = dp_y;
    assign rsp1_y     = dp_y;

endmodule

// File: tb/tb_vadd_arbiter.sv
// Bench for vadd_arbiter: LAT=1 and LAT=3 instances share stimulus, each with its own
// vadd model and in-order scoreboard of {id, y, due cycle}.
module tb_vadd_arbiter;
    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int CNTW  = 16;
    localparam int VW    = LANES * WIDTH;

    typedef struct {
        logic          id;
        logic [VW-1:0] y;
        int            due;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          req0_valid = 1'b1;
    logic          req1_valid = 1'b0;
    logic [VW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;

    logic [1:0]           r0_rdy, r1_rdy, rsp0_v, rsp1_v, dp_en, busy;
    logic [1:0][VW-1:0]   rsp0_y, rsp1_y, dp_a, dp_b, dp_y;
    logic [1:0][CNTW-1:0] d0_cnt, d1_cnt;

    vadd_arbiter #(.LAT(1), .LANES(LANES), .WIDTH(WIDTH), .CNTW(CNTW)) u_dut_l1 (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(r0_rdy[0]), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r1_rdy[0]), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_v[0]), .rsp0_y(rsp0_y[0]), .rsp1_valid(rsp1_v[0]), .rsp1_y(rsp1_y[0]),
        .dp_en(dp_en[0]), .dp_a(dp_a[0]), .dp_b(dp_b[0]), .dp_y(dp_y[0]),
        .busy(busy[0]), .done0_cnt(d0_cnt[0]), .done1_cnt(d1_cnt[0])
    );

    vadd_arbiter #(.LAT(3), .LANES(LANES), .WIDTH(WIDTH), .CNTW(CNTW)) u_dut_l3 (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(r0_rdy[1]), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r1_rdy[1]), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_v[1]), .rsp0_y(rsp0_y[1]), .rsp1_valid(rsp1_v[1]), .rsp1_y(rsp1_y[1]),
        .dp_en(dp_en[1]), .dp_a(dp_a[1]), .dp_b(dp_b[1]), .dp_y(dp_y[1]),
        .busy(busy[1]), .done0_cnt(d0_cnt[1]), .done1_cnt(d1_cnt[1])
    );

    function automatic logic [VW-1:0] vsum(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] + b[i*WIDTH +: WIDTH];
        return r;
    endfunction

    // vadd models: advance only while en is high
    logic [VW-1:0] m1_s;
    logic [VW-1:0] m3_s [3];
    always_ff @(posedge clock) if (dp_en[0]) m1_s <= vsum(dp_a[0], dp_b[0]);
    always_ff @(posedge clock) begin
        if (dp_en[1]) begin
            m3_s[0] <= vsum(dp_a[1], dp_b[1]);
            m3_s[1] <= m3_s[0];
            m3_s[2] <= m3_s[1];
        end
    end
    assign dp_y[0] = m1_s;
    assign dp_y[1] = m3_s[2];

    int cyc = 0;
    always_ff @(posedge clock) cyc <= cyc + 1;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t sbq0[$];
    ent_t sbq1[$];
    int   exp_cnt [2][2];
    logic last_g = 1'b1;
    logic [VW-1:0] last_a = '0, last_b = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? sbq0.size() : sbq1.size();
    endfunction

    function automatic ent_t sb_front(input int d);
        return (d == 0) ? sbq0[0] : sbq1[0];
    endfunction

    task automatic sb_push(input int d, input ent_t e);
        if (d == 0) sbq0.push_back(e); else sbq1.push_back(e);
    endtask

    task automatic sb_drop(input int d);
        if (d == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
    endtask

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (sb_size(d) > 0 && sb_front(d).due == cyc) begin
                ent_t e;
                e = sb_front(d);
                sb_drop(d);
                check_val($sformatf("rsp_valid[%0d]", d), {rsp1_v[d], rsp0_v[d]}, e.id ? 2'b10 : 2'b01);
                check_val($sformatf("rsp_y[%0d]", d), e.id ? rsp1_y[d] : rsp0_y[d], e.y);
            end else if ({rsp1_v[d], rsp0_v[d]} != 2'b00) begin
                check_val($sformatf("rsp_unexp[%0d]", d), {rsp1_v[d], rsp0_v[d]}, 2'b00);
            end
        end
    end

    task automatic drive(input logic v0, input logic [VW-1:0] a0, input logic [VW-1:0] b0,
                         input logic [VW-1:0] y0, input logic v1, input logic [VW-1:0] a1,
                         input logic [VW-1:0] b1, input logic [VW-1:0] y1);
        logic g0, g1;
        ent_t e;
        @(posedge clock); #1;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        @(negedge clock);
        g0 = v0 && (!v1 || last_g);
        g1 = v1 && !g0;
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("ready0[%0d]", d), r0_rdy[d], g0);
            check_val($sformatf("ready1[%0d]", d), r1_rdy[d], g1);
        end
        if (g0 || g1) begin
            last_g = g1;
            last_a = g1 ? a1 : a0;
            last_b = g1 ? b1 : b0;
            for (int d = 0; d < 2; d++) begin
                e.id  = g1;
                e.y   = g1 ? y1 : y0;
                e.due = cyc + 1 + lat_of(d);
                sb_push(d, e);
                exp_cnt[d][g1 ? 1 : 0]++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic op0(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] y);
        drive(1'b1, a, b, y, 1'b0, '0, '0, '0);
    endtask

    // Requests left asserted by the caller stay up for the first reset cycle.
    task automatic do_reset(input int n);
        @(posedge clock); #1;
        reset = 1'b1;
        sbq0.delete();
        sbq1.delete();
        for (int d = 0; d < 2; d++) begin exp_cnt[d][0] = 0; exp_cnt[d][1] = 0; end
        last_g = 1'b1; last_a = '0; last_b = '0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) check_val($sformatf("rst_ready[%0d]", d), {r1_rdy[d], r0_rdy[d]}, 2'b00);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n - 1) @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("rst_busy[%0d]", d), {busy[d], dp_en[d]}, 2'b00);
            check_val($sformatf("rst_dp[%0d]", d), {dp_a[d], dp_b[d]}, '0);
            check_val($sformatf("rst_cnt[%0d]", d), {d1_cnt[d], d0_cnt[d]}, '0);
        end
    endtask

    task automatic check_counts(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("%s_cnt0[%0d]", tag, d), d0_cnt[d], exp_cnt[d][0]);
            check_val($sformatf("%s_cnt1[%0d]", tag, d), d1_cnt[d], exp_cnt[d][1]);
        end
    endtask

    initial begin
        logic [VW-1:0] ra0, rb0, ra1, rb1;
        logic          rv0, rv1;

        do_reset(3);

        // single op on requester 0, then idle gating
        op0({8'd2, 8'd2, 8'd8, 8'd10}, {8'd0, 8'd4, 8'd8, 8'd1}, {8'd2, 8'd6, 8'd16, 8'd11});
        idle(1);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("issue_en[%0d]", d), dp_en[d], 1'b1);
            check_val($sformatf("issue_a[%0d]", d), dp_a[d], last_a);
        end
        idle(10);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("idle_gate[%0d]", d), {busy[d], dp_en[d]}, 2'b00);
            check_val($sformatf("idle_hold[%0d]", d), {dp_a[d], dp_b[d]}, {last_a, last_b});
        end
        check_counts("single");

        // tie alternation from reset
        do_reset(2);
        for (int i = 0; i < 4; i++)
            drive(1'b1, {4{8'd1}}, {4{8'd1}}, {4{8'd2}}, 1'b1, {4{8'd3}}, {4{8'd3}}, {4{8'd6}});
        idle(6);
        check_counts("tie");

        // per-lane wrap, no carry between lanes
        drive(1'b0, '0, '0, '0, 1'b1, {8'd200, 8'd127, 8'd255, 8'd0}, {8'd100, 8'd1, 8'd1, 8'd0},
              {8'd44, 8'd128, 8'd0, 8'd0});
        idle(6);
        check_counts("wrap");

        // random traffic
        for (int i = 0; i < 60; i++) begin
            rv0 = 1'($urandom_range(0, 1)); rv1 = 1'($urandom_range(0, 1));
            ra0 = $urandom(); rb0 = $urandom(); ra1 = $urandom(); rb1 = $urandom();
            drive(rv0, ra0, rb0, vsum(ra0, rb0), rv1, ra1, rb1, vsum(ra1, rb1));
        end
        idle(6);
        check_counts("rand");

        // reset while a requester-1 op is in flight
        drive(1'b0, '0, '0, '0, 1'b1, {4{8'd9}}, {4{8'd9}}, {4{8'd18}});
        do_reset(2);
        idle(6);
        check_counts("rstmid");
        drive(1'b1, {4{8'd4}}, {4{8'd4}}, {4{8'd8}}, 1'b1, {4{8'd5}}, {4{8'd5}}, {4{8'd10}});
        idle(6);

        // back-to-back stream from requester 0
        for (int i = 0; i < 5; i++)
            op0({4{8'(i)}}, {4{8'(10 * i)}}, {4{8'(11 * i)}});
        idle(8);
        check_counts("stream");

        for (int d = 0; d < 2; d++) check_val($sformatf("sb_empty[%0d]", d), sb_size(d), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
